// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 unsigned multiplier reusing one 8x8 Wallace multiplier over four byte steps.
// Define MUL16_SEQ_ZERO_SKIP_EN to skip steps whose operand bytes contain a zero.
module wallace_8 #(
    parameter int APPROX_TYPE = 0
) (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    // non-zero approximation types drop partial-product bits in the lowest 2*APPROX_TYPE columns
    localparam logic [15:0] COL_MASK = 16'hFFFF << (2 * APPROX_TYPE);
    logic [15:0] s, c, t, row;
    always_comb begin
        s = {8'b0, a_i & {8{b_i[0]}}} & COL_MASK;
        c = ({8'b0, a_i & {8{b_i[1]}}} << 1) & COL_MASK;
        t = '0;
        row = '0;
        for (int i = 2; i < 8; i++) begin
            row = ({8'b0, a_i & {8{b_i[i]}}} << i) & COL_MASK;
            t = s ^ c ^ row;
            c = ((s & c) | (s & row) | (c & row)) << 1;
            s = t;
        end
    end
    assign p_o = s + c;
endmodule

module mul16_seq #(
    parameter int APPROX_TYPE = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_p,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, pp;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  run_q, run_d, run_new, later;
    logic [4:0]  sh;

    function automatic logic [1:0] first_step(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    wallace_8 #(.APPROX_TYPE(APPROX_TYPE)) u_wal (
        .a_i(step_q[1] ? a_q[15:8] : a_q[7:0]),
        .b_i(step_q[0] ? b_q[15:8] : b_q[7:0]),
        .p_o(pp)
    );

`ifdef MUL16_SEQ_ZERO_SKIP_EN
    // bit n set means step n has two non-zero operand bytes and must run
    assign run_new = {(|i_a[15:8]) & (|i_b[15:8]), (|i_a[15:8]) & (|i_b[7:0]),
                      (|i_a[7:0]) & (|i_b[15:8]), (|i_a[7:0]) & (|i_b[7:0])};
`else
    assign run_new = 4'hF;
`endif

    // steps 1 and 2 shift by 8, step 3 by 16
    assign sh    = {&step_q, ^step_q, 3'b000};
    assign later = run_q & (4'b1110 << step_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        run_d   = run_q;
        if (state_q == IDLE && i_valid) begin
            state_d = MUL;
            a_d     = i_a;
            b_d     = i_b;
            acc_d   = '0;
            run_d   = run_new;
            step_d  = first_step(run_new);
        end else if (state_q == MUL) begin
            acc_d = acc_q + (run_q[step_q] ? ({16'b0, pp} << sh) : 32'd0);
            if (|later) step_d = first_step(later);
            else state_d = DONE;
        end else if (state_q == DONE && i_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            run_q   <= run_d;
        end
    end

    assign o_ready = state_q == IDLE;
    assign o_busy  = state_q == MUL;
    assign o_valid = state_q == DONE;
    assign o_p     = acc_q;
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: directed and random checks of mul16_seq against plain-arithmetic products and latencies.
module tb_mul16_seq;
    logic        i_clk = 0, i_rst = 0, i_valid = 0, i_ready = 1;
    logic [15:0] i_a = 0, i_b = 0;
    logic        o_ready, o_valid, o_busy;
    logic [31:0] o_p;
    int          errors = 0, checks = 0;

    mul16_seq dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid),
        .o_ready(o_ready), .o_p(o_p), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL16_SEQ_ZERO_SKIP_EN
        int n = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (a[8*i +: 8] != 0 && b[8*j +: 8] != 0) n++;
        return n == 0 ? 1 : n;
`else
        return 4;
`endif
    endfunction

    // one transaction; hold > 0 keeps i_ready low for that many cycles in DONE
    task automatic run(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [31:0] exp_p;
        int n, busy, lat;
        exp_p = {16'b0, a} * {16'b0, b};
        lat = exp_lat(a, b);
        n = 0;
        chk("ready_before", {31'b0, o_ready}, 1);
        i_a = a;
        i_b = b;
        i_valid = 1;
        i_ready = (hold == 0);
        @(posedge i_clk); #1;
        i_valid = 0;
        busy = int'(o_busy);
        while (!o_valid && n < 20) begin
            @(posedge i_clk); #1;
            n++;
            if (!o_valid) busy += int'(o_busy);
        end
        chk("latency", n, lat);
        chk("busy_cycles", busy, lat);
        chk("product", o_p, exp_p);
        chk("ready_in_done", {31'b0, o_ready}, 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                i_a = 16'($urandom);
                i_b = 16'($urandom);
                i_valid = 1;
            end
            if (i == 4) i_valid = 0;
            @(posedge i_clk); #1;
            chk("hold_product", o_p, exp_p);
            chk("hold_valid", {31'b0, o_valid}, 1);
            chk("hold_ready", {31'b0, o_ready}, 0);
        end
        i_valid = 0;
        i_ready = 1;
        @(posedge i_clk); #1;
        chk("valid_one_cycle", {31'b0, o_valid}, 0);
        chk("ready_after", {31'b0, o_ready}, 1);
        chk("busy_after", {31'b0, o_busy}, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        #2 i_rst = 1;
        #1;
        chk("rst_ready", {31'b0, o_ready}, 1);
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_busy", {31'b0, o_busy}, 0);
        chk("rst_p", o_p, 0);
        @(posedge i_clk); #1;
        i_rst = 0;
        run(16'h1234, 16'h5678, 0);
        chk("req027_const", o_p, 32'h06260060);
        run(16'hFFFF, 16'hFFFF, 0);
        chk("req028_const", o_p, 32'hFFFE0001);
        run(16'h00FF, 16'h0100, 0);
        run(16'h0000, 16'h1234, 0);
        run(16'h1234, 16'h5678, 10);
        // stay idle with i_ready high: nothing should start
        @(posedge i_clk); #1;
        chk("idle_busy", {31'b0, o_busy}, 0);
        chk("idle_valid", {31'b0, o_valid}, 0);
        // abort during step 2
        i_a = 16'h1234;
        i_b = 16'h5678;
        i_valid = 1;
        @(posedge i_clk); #1;
        i_valid = 0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("mid_busy", {31'b0, o_busy}, 1);
        #2 i_rst = 1;
        #1;
        chk("abort_valid", {31'b0, o_valid}, 0);
        chk("abort_p", o_p, 0);
        chk("abort_busy", {31'b0, o_busy}, 0);
        chk("abort_ready", {31'b0, o_ready}, 1);
        @(negedge i_clk);
        i_rst = 0;
        @(posedge i_clk); #1;
        run(16'h0003, 16'h0005, 0);
        chk("after_reset_const", o_p, 32'h0000000F);
        for (int k = 0; k < 30; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[7:0] = 0;
            if ($urandom_range(0, 3) == 0) ra[15:8] = 0;
            if ($urandom_range(0, 3) == 0) rb[7:0] = 0;
            if ($urandom_range(0, 3) == 0) rb[15:8] = 0;
            run(ra, rb, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL expose parameter APPROX_TYPE, default 0, the approximation type passed unchanged to its single internal wallace_8 instance.
REQ-002 Port i_clk, input, 1: the single clock; every register updates on its rising edge.
REQ-003 Port i_rst, input, 1: the reset, which is asynchronous and active-high.
REQ-004 Port i_a, input, 16: unsigned multiplicand, sampled on acceptance.
REQ-005 Port i_b, input, 16: unsigned multiplier, sampled on acceptance.
REQ-006 Port i_valid, input, 1: the request is valid.
REQ-007 Port o_ready, output, 1: the block can accept a request; equals (state==IDLE).
REQ-008 Port o_p, output, 32: the product, registered.
REQ-009 Port o_valid, output, 1: o_p is valid; equals (state==DONE).
REQ-010 Port i_ready, input, 1: the downstream consumer accepts o_p.
REQ-011 Port o_busy, output, 1: high while state==MUL.

Function
REQ-012 The product SHALL be computed through exactly one wallace_8 instance, time-multiplexed over the byte partial products.
- Step 0: a[7:0]*b[7:0], shift 0.
- Step 1: a[7:0]*b[15:8], shift 8.
- Step 2: a[15:8]*b[7:0], shift 8.
- Step 3: a[15:8]*b[15:8], shift 16.
REQ-013 The FSM SHALL have three states, IDLE, MUL and DONE, with these transitions:
- IDLE->MUL on i_valid&&o_ready.
- MUL->DONE after the last step.
- DONE->IDLE on i_ready.
- Otherwise the state holds.
REQ-014 On acceptance, the block SHALL:
- register i_a and i_b into operand registers;
- clear the 32-bit accumulator;
- set the step counter to the first step to execute.
REQ-015 In MUL, each cycle SHALL add the zero-extended, shifted partial product of the current step into the accumulator, modulo 2^32 (no overflow is possible for exact operation); the step counter then advances.
REQ-016 The step counter is 2 bits; after step 3 the FSM SHALL enter DONE and SHALL NOT wrap the counter back to step 0.
REQ-017 o_p SHALL equal the accumulator and SHALL remain stable throughout DONE until the cycle in which i_ready is sampled high.
REQ-018 Latency without skipping: acceptance on edge k, so o_valid is high after edge k+4.
REQ-019 i_valid while o_ready==0 SHALL be ignored; the operand registers do not change.
REQ-020 i_ready while o_valid==0 SHALL have no effect.
REQ-021 With i_ready held high, o_valid SHALL last exactly 1 cycle, and o_ready SHALL be high on the following cycle; a new request is accepted no earlier than that cycle.
REQ-022 With APPROX_TYPE=0, o_p SHALL equal a*b exactly for every input pair.

Reset
REQ-023 While i_rst is high, regardless of i_clk, the block SHALL hold:
- state=IDLE and the step counter at 0;
- accumulator, operand registers and o_p at 0;
- o_valid=0, o_busy=0, o_ready=1.
REQ-024 An i_rst assertion during MUL or DONE SHALL abort the operation with no residual output; the first request after reset SHALL compute correctly.

Configuration
REQ-025 The macro MUL16_SEQ_ZERO_SKIP_EN, when defined, SHALL enable zero-skipping:
- At acceptance, the block computes a 4-bit skip mask; a step is skipped if either of its operand bytes is zero.
- MUL executes only the non-skipped steps, in ascending order, at one cycle each.
- If all four steps are skipped, MUL lasts 1 cycle, adds nothing, and o_p=0.
- Latency is therefore max(1, number of non-zero steps) cycles from acceptance to o_valid.
REQ-026 When MUL16_SEQ_ZERO_SKIP_EN is undefined, all four steps SHALL always execute, and the latency is always 4 cycles.

Verification
REQ-027 a=0x1234, b=0x5678 -> o_p=0x06260060, o_valid 4 cycles after acceptance, o_busy high for 4 cycles.
REQ-028 a=0xFFFF, b=0xFFFF -> o_p=0xFFFE0001, with no overflow artefact.
REQ-029 a=0x00FF, b=0x0100 -> o_p=0x0000FF00; latency is 1 cycle with MUL16_SEQ_ZERO_SKIP_EN, 4 cycles without.
REQ-030 a=0x0000, b=0x1234 -> o_p=0.
- With the macro: latency 1.
- Without the macro: latency 4.
REQ-031 Backpressure case:
- Stimulus: hold i_ready=0 for 10 cycles in DONE, and pulse i_valid with new operands during that time.
- Required response: o_p is stable, o_ready=0, and the new request is ignored; after i_ready=1, o_ready rises the next cycle.
REQ-032 Reset mid-operation case:
- Stimulus: assert i_rst at step 2 of 0x1234*0x5678, asynchronously to i_clk.
- Required response: o_valid=0 and o_p=0 immediately; a subsequent 0x0003*0x0005 returns 0x0000000F.
